ex_muldiv_unit: RTL
===================

// Module: ex_muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit in the execute stage. Consumes the operand bundle
//  latched by the decode/execute pipeline register and produces HI/LO results.
//  Drives a stall request back to the fetch/decode/DE registers while an operation runs.
//  One operation at a time; radix-2 shift-add multiply, restoring divide.
// PARAMETERS
//  WIDTH   32   operand width; HI and LO are each WIDTH bits
// PORTS
//  clk           in   1      clock, rising edge
//  rst_n         in   1      asynchronous active-low reset
//  start         in   1      E-stage instruction is MULT/MULTU/DIV/DIVU (level, held while stalled)
//  op            in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV (sampled with start in IDLE)
//  srcA          in   WIDTH  multiplicand / dividend (E-stage ReadData1E after forwarding)
//  srcB          in   WIDTH  multiplier / divisor    (E-stage ReadData2E after forwarding)
//  flush         in   1      synchronous abort (same cycle the DE register clears)
//  stall         out  1      freeze F, D and DE registers
//  busy          out  1      state != IDLE
//  done          out  1      one-cycle pulse: hi/lo valid with the new result
//  hi            out  WIDTH  MULT: upper product; DIV: remainder
//  lo            out  WIDTH  MULT: lower product; DIV: quotient
//  div_by_zero   out  1      divide with srcB==0; held until next accepted start
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, hi=0, lo=0, done=0, div_by_zero=0, internal regs 0.
//  States: IDLE -> CALC -> FIX -> DONE -> IDLE.
//  IDLE: on start=1 && flush=0 capture op, |srcA|, |srcB| (magnitudes only for signed ops),
//    sign flags, clear div_by_zero, load count=WIDTH-1, go CALC.
//  CALC: one iteration per cycle; count decrements; at count==0 go FIX (exactly WIDTH cycles).
//    Multiply: 2*WIDTH-bit accumulator, add multiplicand if LSB of multiplier set, shift right.
//    Divide: shift remainder:quotient left 1, trial-subtract divisor, set quotient bit if >=0.
//  FIX: apply signs: MULT negates 2*WIDTH product if signs differ; DIV negates quotient if
//    signs differ, remainder takes dividend sign. Write hi/lo; go DONE.
//  DONE: done=1 for this cycle only; start ignored; next edge -> IDLE.
//  Latency: start accepted at edge t -> done high in cycle after edge t+WIDTH+1 (WIDTH+2 cycles).
//  stall = (state==IDLE && start && !flush) | (state==CALC) | (state==FIX); combinational.
//    stall is 0 in DONE so the instruction leaves E on the DONE edge; no double issue.
//  hi/lo change only in FIX; hold value otherwise (readable by MFHI/MFLO any time).
//  Divide by zero: detected at accept; runs full latency; result hi=srcA (raw), lo=all ones,
//    div_by_zero=1 from FIX onward until next accepted start.
//  Signed overflow DIV(-2^(WIDTH-1), -1): lo=0x8000_0000, hi=0 (falls out of magnitude path).
//  flush=1 in any state: next edge -> IDLE, hi/lo/div_by_zero unchanged, no done pulse.
//    flush and start together in IDLE: flush wins, nothing accepted.
//  rst_n low mid-operation: immediate return to reset values; no done pulse.
//  Magnitude of most negative value is its unsigned bit pattern (2^(WIDTH-1)).
// TESTING
//  MULTU 0xFFFF_FFFF*0xFFFF_FFFF -> after 34 cycles done=1, hi=0xFFFF_FFFE, lo=0x0000_0001.
//  MULT -7*3 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFEB; stall high cycles 0..32, low in done cycle.
//  DIV -7/2 -> lo=0xFFFF_FFFD, hi=0xFFFF_FFFF; DIVU 100/7 -> lo=14, hi=2.
//  DIVU 5/0 -> lo=0xFFFF_FFFF, hi=5, div_by_zero=1; next MULTU start clears div_by_zero.
//  flush at CALC cycle 10 after prior result hi=2,lo=14 -> IDLE next cycle, no done, hi/lo held.
//  rst_n pulsed low mid-CALC -> hi=lo=0, busy=0, stall=0 asynchronously; new start works.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit for the execute stage: radix-2 shift-add multiply and
// restoring divide on operand magnitudes, with sign fix-up in a final cycle.
module ex_muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] srcA,
   input  logic [WIDTH-1:0] srcB,
   input  logic             flush,
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

   state_e               state_q, state_d;
   logic                 is_div_q, is_div_d;
   logic                 neg_a_q, neg_a_d;
   logic                 neg_b_q, neg_b_d;
   logic                 dbz_pend_q, dbz_pend_d;
   logic                 div_by_zero_q, div_by_zero_d;
   logic [WIDTH-1:0]     opnd_q, opnd_d;
   logic [WIDTH-1:0]     raw_a_q, raw_a_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [CntW-1:0]      count_q, count_d;
   logic [WIDTH-1:0]     hi_q, hi_d;
   logic [WIDTH-1:0]     lo_q, lo_d;

   logic                 sgn_a, sgn_b;
   logic [WIDTH-1:0]     mag_a, mag_b;
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_next;
   logic [WIDTH:0]       rem_sh;
   logic [WIDTH:0]       trial;
   logic                 div_ge;
   logic [2*WIDTH-1:0]   div_next;
   logic [2*WIDTH-1:0]   prod_fix;
   logic [WIDTH-1:0]     quo_fix, rem_fix;

   // Magnitudes: the most negative value maps onto its own unsigned bit pattern.
   always_comb begin
      sgn_a = op[0] & srcA[WIDTH-1];
      sgn_b = op[0] & srcB[WIDTH-1];
      mag_a = sgn_a ? (~srcA + 1'b1) : srcA;
      mag_b = sgn_b ? (~srcB + 1'b1) : srcB;
   end

   // Multiply: acc = {partial product, remaining multiplier bits}; carry re-enters at the top.
   always_comb begin
      mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_next = {mul_sum, acc_q[WIDTH-1:1]};
   end

   // Divide: acc = {remainder, dividend/quotient}; the shifted remainder needs one extra bit.
   always_comb begin
      rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
      trial    = rem_sh - {1'b0, opnd_q};
      div_ge   = (rem_sh >= {1'b0, opnd_q});
      div_next = {(div_ge ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};
   end

   always_comb begin
      prod_fix = (neg_a_q ^ neg_b_q) ? (~acc_q + 1'b1) : acc_q;
      quo_fix  = (neg_a_q ^ neg_b_q) ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
      rem_fix  = neg_a_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
   end

   always_comb begin
      state_d       = state_q;
      is_div_d      = is_div_q;
      neg_a_d       = neg_a_q;
      neg_b_d       = neg_b_q;
      dbz_pend_d    = dbz_pend_q;
      div_by_zero_d = div_by_zero_q;
      opnd_d        = opnd_q;
      raw_a_d       = raw_a_q;
      acc_d         = acc_q;
      count_d       = count_q;
      hi_d          = hi_q;
      lo_d          = lo_q;

      if (flush) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  state_d       = StCalc;
                  is_div_d      = op[1];
                  neg_a_d       = sgn_a;
                  neg_b_d       = sgn_b;
                  dbz_pend_d    = op[1] && (srcB == '0);
                  div_by_zero_d = 1'b0;
                  opnd_d        = op[1] ? mag_b : mag_a;
                  raw_a_d       = srcA;
                  acc_d         = {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
                  count_d       = CntW'(WIDTH - 1);
               end
            end
            StCalc: begin
               acc_d = is_div_q ? div_next : mul_next;
               if (count_q == '0) begin
                  state_d = StFix;
               end else begin
                  count_d = count_q - 1'b1;
               end
            end
            StFix: begin
               state_d = StDone;
               if (!is_div_q) begin
                  hi_d = prod_fix[2*WIDTH-1:WIDTH];
                  lo_d = prod_fix[WIDTH-1:0];
               end else if (dbz_pend_q) begin
                  hi_d          = raw_a_q;
                  lo_d          = '1;
                  div_by_zero_d = 1'b1;
               end else begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end
            end
            StDone: begin
               state_d = StIdle;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         is_div_q      <= 1'b0;
         neg_a_q       <= 1'b0;
         neg_b_q       <= 1'b0;
         dbz_pend_q    <= 1'b0;
         div_by_zero_q <= 1'b0;
         opnd_q        <= '0;
         raw_a_q       <= '0;
         acc_q         <= '0;
         count_q       <= '0;
         hi_q          <= '0;
         lo_q          <= '0;
      end else begin
         state_q       <= state_d;
         is_div_q      <= is_div_d;
         neg_a_q       <= neg_a_d;
         neg_b_q       <= neg_b_d;
         dbz_pend_q    <= dbz_pend_d;
         div_by_zero_q <= div_by_zero_d;
         opnd_q        <= opnd_d;
         raw_a_q       <= raw_a_d;
         acc_q         <= acc_d;
         count_q       <= count_d;
         hi_q          <= hi_d;
         lo_q          <= lo_d;
      end
   end

   // Stall drops in DONE so the instruction leaves E on the DONE edge exactly once.
   always_comb begin
      stall       = ((state_q == StIdle) && start && !flush) ||
                    (state_q == StCalc) || (state_q == StFix);
      busy        = (state_q != StIdle);
      done        = (state_q == StDone);
      hi          = hi_q;
      lo          = lo_q;
      div_by_zero = div_by_zero_q;
   end

endmodule
